// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter that serialises four cores' data-memory requests onto
// one single-port RAM, one access at a time, with a per-core completion ack.
module dmem_rr_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req_rd,
  input  logic [3:0]          req_wr,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [4*DATA_W-1:0] req_wdata,
  output logic [3:0]          ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wr,
  output logic                mem_rd,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          fsm_state
);

  // Handshake: a core raises req_rd/req_wr with addr/wdata stable and holds
  // them until it sees its ack bit; ack is a one-cycle pulse and the core
  // drops the request on the edge that ends that cycle.

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q;
  logic [1:0]         g_q;
  logic               op_wr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;

  logic [3:0]         req;
  logic               any_req;
  logic [1:0]         gnt_idx;
  logic [1:0]         cand;
  logic               found;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_wr;

  assign req     = req_rd | req_wr;
  assign any_req = |req;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    gnt_idx = ptr_q;
    cand    = ptr_q;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (gnt_idx == 2'(k)) begin
        sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[k*DATA_W +: DATA_W];
        sel_wr    = req_wr[k];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = op_wr_q ? DONE : WAIT;
      WAIT:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: grant latch, read-latency counter, read capture, pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      g_q     <= '0;
      op_wr_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            g_q     <= gnt_idx;
            op_wr_q <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
          end
        end
        ACCESS: begin
          if (!op_wr_q) cnt_q <= CNT_W'(RD_LAT);
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) rdata_q <= mem_rdata;
        end
        DONE: begin
          ptr_q <= g_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    ack    = '0;
    mem_wr = 1'b0;
    mem_rd = 1'b0;
    busy   = (state_q != IDLE);
    case (state_q)
      ACCESS: begin
        mem_wr = op_wr_q;
        mem_rd = !op_wr_q;
      end
      DONE:    ack[g_q] = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Bench for dmem_rr_arbiter: a per-cycle vector table at RD_LAT=1 plus
// hand sequences for arbitration order, fairness and reset at RD_LAT=3.
module tb_dmem_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance with RD_LAT=1
  logic [3:0]  rd1, wr1, ack1;
  logic [63:0] addr1, wd1;
  logic [15:0] rdata1, maddr1, mwd1, mrdata1;
  logic        busy1, mwr1, mrd1;
  logic [1:0]  st1;

  // Instance with RD_LAT=3
  logic [3:0]  rd3, wr3, ack3;
  logic [63:0] addr3, wd3;
  logic [15:0] rdata3, maddr3, mwd3, mrdata3;
  logic        busy3, mwr3, mrd3;
  logic [1:0]  st3;

  dmem_rr_arbiter #(.DATA_W(16), .ADDR_W(16), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .req_rd(rd1), .req_wr(wr1), .req_addr(addr1),
    .req_wdata(wd1), .ack(ack1), .rdata(rdata1), .busy(busy1),
    .mem_addr(maddr1), .mem_wdata(mwd1), .mem_wr(mwr1), .mem_rd(mrd1),
    .mem_rdata(mrdata1), .fsm_state(st1)
  );

  dmem_rr_arbiter #(.DATA_W(16), .ADDR_W(16), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .req_rd(rd3), .req_wr(wr3), .req_addr(addr3),
    .req_wdata(wd3), .ack(ack3), .rdata(rdata3), .busy(busy3),
    .mem_addr(maddr3), .mem_wdata(mwd3), .mem_wr(mwr3), .mem_rd(mrd3),
    .mem_rdata(mrdata3), .fsm_state(st3)
  );

  // RAM models: unwritten words read as addr ^ 16'hA5A5; idle pipe data is DEAD.
  logic [15:0]   ram1 [0:1023];
  logic [1023:0] wv1 = '0;
  logic [15:0]   p1;
  logic [15:0]   ram3 [0:1023];
  logic [1023:0] wv3 = '0;
  logic [15:0]   q3 [0:2];

  always @(posedge clk) begin
    if (mwr1) begin
      ram1[maddr1[9:0]] <= mwd1;
      wv1[maddr1[9:0]]  <= 1'b1;
    end
    p1 <= mrd1 ? (wv1[maddr1[9:0]] ? ram1[maddr1[9:0]] : (maddr1 ^ 16'hA5A5)) : 16'hDEAD;
  end
  assign mrdata1 = p1;

  always @(posedge clk) begin
    if (mwr3) begin
      ram3[maddr3[9:0]] <= mwd3;
      wv3[maddr3[9:0]]  <= 1'b1;
    end
    q3[0] <= mrd3 ? (wv3[maddr3[9:0]] ? ram3[maddr3[9:0]] : (maddr3 ^ 16'hA5A5)) : 16'hDEAD;
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign mrdata3 = q3[2];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int s, input int max, output int n, output logic [3:0] a);
    a = '0;
    n = 0;
    while (n < max && a == 4'h0) begin
      tick();
      n++;
      a = (s == 1) ? ack1 : ack3;
    end
  endtask

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  ack;
    logic        busy;
    logic        mwr;
    logic        mrd;
    logic [15:0] maddr;
    logic [15:0] mwdata;
    logic [15:0] rdata;
  } vec_t;

  vec_t       vt [12];
  logic [1:0] exp_q [$];
  logic [15:0] rd_exp [4];
  int          got, n, idx;
  logic [3:0]  a;

  initial begin
    // Core 2 write, core 0 read-back, core 1 read+write treated as write.
    vt[0]  = '{4'h0, 4'h4, 64'h0000_0010_0000_0000, 64'h0000_BEEF_0000_0000, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000};
    vt[1]  = '{4'h0, 4'h4, 64'h0000_0010_0000_0000, 64'h0000_BEEF_0000_0000, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000};
    vt[2]  = '{4'h0, 4'h4, 64'h0000_0010_0000_0000, 64'h0000_BEEF_0000_0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000};
    vt[3]  = '{4'h1, 4'h0, 64'h0000_0000_0000_0010, 64'h0,                   4'h0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000};
    vt[4]  = '{4'h1, 4'h0, 64'h0000_0000_0000_0010, 64'h0,                   4'h0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000};
    vt[5]  = '{4'h1, 4'h0, 64'h0000_0000_0000_0010, 64'h0,                   4'h1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vt[6]  = '{4'h0, 4'h0, 64'h0000_0000_0000_0010, 64'h0,                   4'h0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vt[7]  = '{4'h0, 4'h0, 64'h0,                   64'h0,                   4'h0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vt[8]  = '{4'h2, 4'h2, 64'h0000_0000_0020_0000, 64'h0000_0000_1234_0000, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234, 16'hBEEF};
    vt[9]  = '{4'h2, 4'h2, 64'h0000_0000_0020_0000, 64'h0000_0000_1234_0000, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234, 16'hBEEF};
    vt[10] = '{4'h2, 4'h2, 64'h0000_0000_0020_0000, 64'h0000_0000_1234_0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h1234, 16'hBEEF};
    vt[11] = '{4'h0, 4'h0, 64'h0,                   64'h0,                   4'h0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h1234, 16'hBEEF};
    rd_exp = '{16'hA4A5, 16'hA4A4, 16'hA4A7, 16'hA4A6};

    rst = 1'b1;
    rd1 = '0; wr1 = '0; addr1 = '0; wd1 = '0;
    rd3 = '0; wr3 = '0; addr3 = '0; wd3 = '0;
    tick();
    tick();
    check("rst_ack", 0, 64'(ack1), 64'h0);
    check("rst_busy", 0, 64'(busy1), 64'h0);
    check("rst_rdata", 0, 64'(rdata1), 64'h0);
    check("rst_maddr", 0, 64'(maddr1), 64'h0);
    check("rst_mwdata", 0, 64'(mwd1), 64'h0);
    check("rst_strobes", 0, 64'({mwr1, mrd1}), 64'h0);
    rst = 1'b0;
    tick();

    for (int r = 0; r < 12; r++) begin
      rd1 = vt[r].rd; wr1 = vt[r].wr; addr1 = vt[r].addr; wd1 = vt[r].wdata;
      tick();
      check("vec_ack", r, 64'(ack1), 64'(vt[r].ack));
      check("vec_busy", r, 64'(busy1), 64'(vt[r].busy));
      check("vec_mem_wr", r, 64'(mwr1), 64'(vt[r].mwr));
      check("vec_mem_rd", r, 64'(mrd1), 64'(vt[r].mrd));
      check("vec_mem_addr", r, 64'(maddr1), 64'(vt[r].maddr));
      check("vec_mem_wdata", r, 64'(mwd1), 64'(vt[r].mwdata));
      check("vec_rdata", r, 64'(rdata1), 64'(vt[r].rdata));
    end

    // All four cores read at once after reset: grants 0,1,2,3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addr1 = 64'h0103_0102_0101_0100;
    rd1 = 4'hF;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    got = 0;
    for (int c = 0; c < 80 && got < 4; c++) begin
      tick();
      if (ack1 != 4'h0) begin
        check("ack_onehot", got, 64'($countones(ack1)), 64'd1);
        idx = 0;
        for (int j = 0; j < 4; j++) if (ack1[j]) idx = j;
        check("grant_order", got, 64'(idx), 64'(exp_q.pop_front()));
        check("grant_rdata", got, 64'(rdata1), 64'(rd_exp[idx]));
        rd1[idx] = 1'b0;
        got++;
      end
    end
    check("all4_done", 0, 64'(got), 64'd4);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("no_extra_ack", c, 64'({ack1, busy1}), 64'h0);
    end

    // Cores 0 and 3 request continuously: grants alternate, starting at 0.
    rd1 = 4'b1001;
    exp_q = '{2'd0, 2'd3, 2'd0, 2'd3};
    got = 0;
    for (int c = 0; c < 80 && got < 4; c++) begin
      tick();
      if (ack1 != 4'h0) begin
        idx = 0;
        for (int j = 0; j < 4; j++) if (ack1[j]) idx = j;
        check("fair_order", got, 64'(idx), 64'(exp_q.pop_front()));
        check("fair_rdata", got, 64'(rdata1), 64'(rd_exp[idx]));
        got++;
      end
    end
    check("fair_done", 0, 64'(got), 64'd4);
    rd1 = '0;
    tick();
    tick();

    // RD_LAT=3 instance: write latency 2, read latency 5.
    wr3 = 4'h4; addr3 = 64'h0000_0060_0000_0000; wd3 = 64'h0000_7777_0000_0000;
    wait_ack(3, 20, n, a);
    check("l3_wr_ack", 0, 64'(a), 64'h4);
    check("l3_wr_lat", 0, 64'(n), 64'd2);
    wr3 = '0;
    tick();
    rd3 = 4'h4;
    wait_ack(3, 20, n, a);
    check("l3_rd_ack", 0, 64'(a), 64'h4);
    check("l3_rd_lat", 0, 64'(n), 64'd5);
    check("l3_rd_data", 0, 64'(rdata3), 64'h7777);
    rd3 = '0;
    tick();

    // Reset during WAIT of a read: abandoned, then grant restarts from core 0.
    rd3 = 4'h4; addr3 = 64'h0000_0050_0000_0000;
    tick();
    tick();
    tick();
    check("l3_in_wait", 0, 64'(st3), 64'd2);
    rst = 1'b1;
    rd3 = '0;
    tick();
    rst = 1'b0;
    check("mid_rst_ack", 0, 64'(ack3), 64'h0);
    check("mid_rst_busy", 0, 64'(busy3), 64'h0);
    check("mid_rst_rdata", 0, 64'(rdata3), 64'h0);
    check("mid_rst_mem", 0, 64'({maddr3, mwd3, mwr3, mrd3}), 64'h0);
    rd3 = 4'b1010; addr3 = 64'h0071_0000_0070_0000;
    wait_ack(3, 20, n, a);
    check("post_rst_grant", 0, 64'(a), 64'h2);
    check("post_rst_rdata", 0, 64'(rdata3), 64'hA5D5);
    rd3 = '0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_rr_arbiter.md
Name: dmem_rr_arbiter

Overview:
- Serialises data-memory requests from the four cores onto the single-port data RAM.
- Sits between the cores' DMADDR/DATAOUT/MEMREAD/MEMWR outputs and the data RAM.
- Arbitrates round-robin, runs one access at a time, and returns read data plus a per-core completion ack.
- Lets the cores stall cleanly on a busy memory instead of colliding on the shared RAM port.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, data address width
- RD_LAT, 1, cycles from the mem_rd cycle to valid mem_rdata (legal 1..4)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_rd  in  4  per-core read request, bit i = core i
- req_wr  in  4  per-core write request
- req_addr  in  4*ADDR_W  core i address at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  4*DATA_W  core i write data, same packing
- ack  out  4  one-cycle completion pulse to the granted core
- rdata  out  DATA_W  last read result, shared by all cores
- busy  out  1  high whenever the FSM is not in IDLE
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_wr  out  1  RAM write strobe, one cycle
- mem_rd  out  1  RAM read strobe, one cycle
- mem_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, ptr=0, grant index g=0.
  - ack=0, rdata=0, busy=0, mem_addr=0, mem_wdata=0, mem_wr=0, mem_rd=0.
  - rst overrides every other event.
- Request rules:
  - req_i = req_rd[i] | req_wr[i].
  - A requester holds req, addr and wdata stable until it sees ack[i], then deasserts on the edge that ends the ack cycle.
  - If req_rd[i] and req_wr[i] are both set, the access is a write.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any req_i is set, grant the first set index searching ptr, ptr+1, ... mod 4.
  - Latch g, op, addr and wdata into mem_addr/mem_wdata; next state ACCESS.
  - With no request, stay in IDLE.
- ACCESS (one cycle):
  - Assert mem_wr (write) or mem_rd (read).
  - Write: next state DONE.
  - Read: load cnt=RD_LAT; next state WAIT.
- WAIT:
  - Decrement cnt each cycle.
  - On the cycle with cnt==1, capture mem_rdata into rdata at the clock edge; next state DONE.
- DONE (one cycle):
  - ack[g]=1, all other ack bits 0.
  - ptr <= (g+1) mod 4; next state IDLE.
- Outputs by state:
  - mem_addr and mem_wdata hold their latched values from grant until the next grant.
  - mem_wr and mem_rd are high only in ACCESS.
  - rdata changes only on read capture; it holds across writes and idle cycles.
- Latency, counted from the IDLE cycle in which the request is seen:
  - Write: ack is high 2 cycles later.
  - Read: ack is high 2+RD_LAT cycles later, with rdata already valid in the ack cycle.
- Back-to-back: one idle (IDLE) cycle separates consecutive accesses. Throughput is one write per 3 cycles or one read per 3+RD_LAT cycles.
- Fairness: a continuously requesting core waits for at most 3 other accesses.
- Requests that change while busy are not observed until IDLE. Withdrawing a request before its ack is illegal.
- Reset mid-operation:
  - The access is abandoned, with no ack and no rdata update.
  - A write whose ACCESS cycle already completed stays committed in the RAM.

Test Plan:
- Core 2 writes addr 0x0010, data 0xBEEF, others idle:
  - mem_wr=1 for exactly one cycle with mem_addr 0x0010 and mem_wdata 0xBEEF.
  - ack=4'b0100 two cycles after the request; busy high for 2 cycles.
- After that write, core 0 reads 0x0010 with a RAM model at RD_LAT=1:
  - ack=4'b0001 three cycles after the request.
  - rdata=0xBEEF in the ack cycle and held afterwards.
- All four cores read distinct addresses at once, held until acked:
  - Grants in order 0,1,2,3; each ack pulses exactly once.
  - The final ptr is 0; each returned rdata matches its address.
- Round-robin fairness:
  - Core 0 requests continuously while core 3 also requests.
  - Grants alternate 0,3,0,3; core 3 is never starved.
- Core 1 asserts req_rd and req_wr together (addr 0x0020, data 0x1234):
  - A write is performed; mem_rd stays 0 and rdata is unchanged.
- rst asserted during WAIT of a read at RD_LAT=3:
  - Next cycle: all outputs 0, busy=0, no ack issued.
  - A subsequent request is then granted starting from core 0.
